// File: rtl/macish_pkg.sv
// Shared constants and helpers for the approximate-capable MAC pipeline.
package macish_pkg;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   // Number of 2x2 cells needed for an operand of data_w bits (base-4 digits squared).
   function automatic int unsigned cell_count(input int unsigned data_w);
      return (data_w / 2) * (data_w / 2);
   endfunction

endpackage

// File: rtl/mul2x2_cell.sv
// Combinational 2x2 multiplier cell; approximate mode maps 3*3 to 7.
module mul2x2_cell
   import macish_pkg::*;
(
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       mode,
   output logic [3:0] p
);

   always_comb begin
      p = {2'b00, a} * {2'b00, b};
      if (mode == MODE_APPROX && a == 2'd3 && b == 2'd3) begin
         p = 4'd7;
      end
   end

endmodule

// File: rtl/macish_pipe.sv
// Three-stage multiply-accumulate pipeline with valid/ready on both sides, a per-sample
// exact/approximate multiplier and optional saturating accumulation.
module macish_pipe
   import macish_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ACC_W    = 24,
   parameter bit          SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] dataa,
   input  logic [DATA_W-1:0] datab,
   input  logic              sload,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf
);

   localparam int unsigned N     = DATA_W / 2;
   localparam int unsigned NCELL = cell_count(DATA_W);
   localparam int unsigned PW    = 2 * DATA_W;
   localparam int unsigned SW    = ACC_W + 1;

   logic              advance;

   logic              s1_valid, s1_sload, s1_mode;
   logic [DATA_W-1:0] s1_a, s1_b;

   logic              s2_valid, s2_sload;
   logic [PW-1:0]     s2_prod;

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              out_valid_q;

   logic [3:0]        cell_p [NCELL];
   logic [PW-1:0]     prod;
   logic [ACC_W-1:0]  base;
   logic [SW-1:0]     sum;

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         mul2x2_cell u_cell (
            .a    (s1_a[2*i +: 2]),
            .b    (s1_b[2*j +: 2]),
            .mode (s1_mode),
            .p    (cell_p[i*N + j])
         );
      end
   end

   always_comb begin
      prod = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            prod = prod + (PW'(cell_p[i*N + j]) << (2 * (i + j)));
         end
      end
   end

   // One extra bit on the sum exposes the carry that drives clamping and ovf.
   always_comb begin
      base  = s2_sload ? '0 : acc_q;
      sum   = {1'b0, base} + SW'(s2_prod);
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W] && SATURATE) begin
         acc_d = '1;
      end
      ovf_d = (s2_sload ? 1'b0 : ovf_q) | sum[ACC_W];
   end

   assign advance   = !out_valid_q || out_ready;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         s1_valid    <= 1'b0;
         s1_sload    <= 1'b0;
         s1_mode     <= MODE_EXACT;
         s1_a        <= '0;
         s1_b        <= '0;
         s2_valid    <= 1'b0;
         s2_sload    <= 1'b0;
         s2_prod     <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (advance) begin
         s1_valid    <= in_valid;
         s1_sload    <= sload;
         s1_mode     <= mode;
         s1_a        <= dataa;
         s1_b        <= datab;
         s2_valid    <= s1_valid;
         s2_sload    <= s1_sload;
         s2_prod     <= prod;
         if (s2_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
         end
         out_valid_q <= s2_valid;
      end
   end

endmodule

// File: tb/tb_macish_pipe.sv
// Bench for macish_pipe: three parameterisations share one stimulus stream and are checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_macish_pipe;

   localparam int DW = 8;

   logic          clk, aclr;
   logic          in_valid, sload, mode, out_ready;
   logic [DW-1:0] dataa, datab;

   logic          in_ready0, in_ready1, in_ready2;
   logic          out_valid0, out_valid1, out_valid2;
   logic [23:0]   acc_out0;
   logic [15:0]   acc_out1, acc_out2;
   logic          ovf0, ovf1, ovf2;

   macish_pipe #(.DATA_W(8), .ACC_W(24), .SATURATE(1'b1)) u_dut0 (
      .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready0), .dataa(dataa),
      .datab(datab), .sload(sload), .mode(mode), .out_valid(out_valid0),
      .out_ready(out_ready), .acc_out(acc_out0), .ovf(ovf0));

   macish_pipe #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b1)) u_dut1 (
      .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready1), .dataa(dataa),
      .datab(datab), .sload(sload), .mode(mode), .out_valid(out_valid1),
      .out_ready(out_ready), .acc_out(acc_out1), .ovf(ovf1));

   macish_pipe #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b0)) u_dut2 (
      .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready2), .dataa(dataa),
      .datab(datab), .sload(sload), .mode(mode), .out_valid(out_valid2),
      .out_ready(out_ready), .acc_out(acc_out2), .ovf(ovf2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int     cnt;     // advancing edges still needed before the result is visible
      longint a0, a1, a2;
      bit     o0, o1, o2;
   } item_t;

   item_t  q[$];
   longint m_acc0 = 0, m_acc1 = 0, m_acc2 = 0;
   bit     m_ovf0 = 0, m_ovf1 = 0, m_ovf2 = 0;

   longint beat_acc0[$], beat_acc1[$], beat_acc2[$];
   bit     beat_ovf0[$], beat_ovf1[$], beat_ovf2[$];
   int     beat_cyc[$], acc_cyc[$];

   // Exact product, minus 2 for every (3,3) digit pair when approximating.
   function automatic longint model_prod(input int a, input int b, input bit md);
      longint p;
      p = longint'(a) * longint'(b);
      if (md) begin
         for (int i = 0; i < DW / 2; i++)
            for (int j = 0; j < DW / 2; j++)
               if (((a >> (2 * i)) & 3) == 3 && ((b >> (2 * j)) & 3) == 3)
                  p = p - (longint'(2) << (2 * (i + j)));
      end
      return p;
   endfunction

   function automatic void acc_step(input int aw, input bit sat, input bit sl, input longint p,
                                    inout longint acc, inout bit ov);
      longint lim, s;
      lim = longint'(1) << aw;
      s   = (sl ? 0 : acc) + p;
      if (sl) ov = 1'b0;
      if (s >= lim) begin
         ov  = 1'b1;
         acc = sat ? lim - 1 : s - lim;
      end else begin
         acc = s;
      end
   endfunction

   item_t it;
   bit    exp_v, adv;
   longint p;

   always @(negedge clk) begin
      if (aclr) begin
         q.delete();
         m_acc0 = 0; m_acc1 = 0; m_acc2 = 0;
         m_ovf0 = 0; m_ovf1 = 0; m_ovf2 = 0;
         chk("rst_out_valid", out_valid0 | out_valid1 | out_valid2, 0);
         chk("rst_in_ready", in_ready0 & in_ready1 & in_ready2, 1);
         chk("rst_acc", acc_out0 | acc_out1 | acc_out2, 0);
         chk("rst_ovf", ovf0 | ovf1 | ovf2, 0);
      end else begin
         exp_v = (q.size() > 0) && (q[0].cnt == 0);
         adv   = !exp_v || out_ready;
         chk("out_valid0", out_valid0, exp_v);
         chk("out_valid1", out_valid1, exp_v);
         chk("out_valid2", out_valid2, exp_v);
         chk("in_ready0", in_ready0, adv);
         chk("in_ready12", in_ready1 & in_ready2, adv);
         if (exp_v) begin
            chk("acc_out0", acc_out0, q[0].a0);
            chk("acc_out1", acc_out1, q[0].a1);
            chk("acc_out2", acc_out2, q[0].a2);
            chk("ovf0", ovf0, q[0].o0);
            chk("ovf1", ovf1, q[0].o1);
            chk("ovf2", ovf2, q[0].o2);
         end
         if (adv) begin
            if (exp_v) begin
               beat_acc0.push_back(acc_out0); beat_ovf0.push_back(ovf0);
               beat_acc1.push_back(acc_out1); beat_ovf1.push_back(ovf1);
               beat_acc2.push_back(acc_out2); beat_ovf2.push_back(ovf2);
               beat_cyc.push_back(cyc);
               void'(q.pop_front());
            end
            foreach (q[i]) if (q[i].cnt > 0) q[i].cnt--;
            if (in_valid) begin
               p = model_prod(int'(dataa), int'(datab), mode);
               acc_step(24, 1'b1, sload, p, m_acc0, m_ovf0);
               acc_step(16, 1'b1, sload, p, m_acc1, m_ovf1);
               acc_step(16, 1'b0, sload, p, m_acc2, m_ovf2);
               it.cnt = 2;
               it.a0 = m_acc0; it.a1 = m_acc1; it.a2 = m_acc2;
               it.o0 = m_ovf0; it.o1 = m_ovf1; it.o2 = m_ovf2;
               q.push_back(it);
               acc_cyc.push_back(cyc + 1);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int a, input int b, input bit sl, input bit md);
      bit got;
      dataa = DW'(a); datab = DW'(b); sload = sl; mode = md; in_valid = 1'b1;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         got = in_ready0;
         @(posedge clk);
         #1;
         if (got) break;
         if (t > 200) begin
            fail_now("send_accept");
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      beat_acc0.delete(); beat_acc1.delete(); beat_acc2.delete();
      beat_ovf0.delete(); beat_ovf1.delete(); beat_ovf2.delete();
      beat_cyc.delete();  acc_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      aclr = 1'b1; in_valid = 1'b0; sload = 1'b0; mode = 1'b0; out_ready = 1'b1;
      dataa = '0; datab = '0;
      #2;
      chk("init_out_valid", out_valid0, 0);
      chk("init_in_ready", in_ready0, 1);
      repeat (2) @(posedge clk);
      #1 aclr = 1'b0;
      idle(2);

      // Exact accumulation, back-to-back, latency 2.
      clear_logs();
      send(200, 100, 1, 0); send(3, 3, 0, 0); send(255, 255, 0, 0);
      idle(6);
      chk("seqA_beats", beat_acc0.size(), 3);
      if (beat_acc0.size() == 3) begin
         chk("seqA_r0", beat_acc0[0], 20000);
         chk("seqA_r1", beat_acc0[1], 20009);
         chk("seqA_r2", beat_acc0[2], 85034);
         chk("seqA_latency", beat_cyc[0], acc_cyc[0] + 2);
         chk("seqA_b2b1", beat_cyc[1], beat_cyc[0] + 1);
         chk("seqA_b2b2", beat_cyc[2], beat_cyc[1] + 1);
      end

      // Approximate vs exact products.
      clear_logs();
      send(3, 3, 1, 1); send(255, 255, 1, 1); send(2, 3, 1, 1); send(255, 255, 1, 0);
      idle(6);
      chk("mode_beats", beat_acc0.size(), 4);
      if (beat_acc0.size() == 4) begin
         chk("approx_3x3", beat_acc0[0], 7);
         chk("approx_255", beat_acc0[1], 50575);
         chk("approx_2x3", beat_acc0[2], 6);
         chk("exact_255", beat_acc0[3], 65025);
      end

      // Saturation and wrap at 16 bits.
      clear_logs();
      send(255, 255, 1, 0); send(255, 255, 0, 0); send(1, 1, 1, 0);
      idle(6);
      chk("sat_beats", beat_acc1.size(), 3);
      if (beat_acc1.size() == 3) begin
         chk("sat_r0", beat_acc1[0], 65025);
         chk("sat_r1", beat_acc1[1], 65535);
         chk("sat_ovf1", beat_ovf1[1], 1);
         chk("sat_r2", beat_acc1[2], 1);
         chk("sat_ovf2", beat_ovf1[2], 0);
         chk("wrap_r1", beat_acc2[1], 64514);
         chk("wrap_ovf1", beat_ovf2[1], 1);
         chk("wrap_r2", beat_acc2[2], 1);
         chk("wide_r1", beat_acc0[1], 130050);
         chk("wide_ovf1", beat_ovf0[1], 0);
      end

      // Backpressure mid-stream.
      clear_logs();
      fork
         begin
            send(1, 1, 1, 0); send(2, 2, 0, 0); send(3, 3, 0, 0);
            send(4, 4, 0, 0); send(5, 5, 0, 0);
         end
         begin
            for (int t = 0; beat_acc0.size() < 2 && t < 100; t++) begin
               @(negedge clk);
               #1;
            end
            @(posedge clk);
            #1 out_ready = 1'b0;
            chk("stall_held_val", acc_out0, 14);
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready0, 0);
               chk("stall_acc_hold", acc_out0, 14);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      idle(8);
      chk("bp_beats", beat_acc0.size(), 5);
      if (beat_acc0.size() == 5) begin
         chk("bp_r0", beat_acc0[0], 1);
         chk("bp_r1", beat_acc0[1], 5);
         chk("bp_r2", beat_acc0[2], 14);
         chk("bp_r3", beat_acc0[3], 30);
         chk("bp_r4", beat_acc0[4], 55);
      end

      // Bubble between samples.
      clear_logs();
      send(6, 7, 1, 0); idle(1); send(2, 2, 0, 0);
      idle(6);
      chk("bubble_beats", beat_acc0.size(), 2);
      if (beat_acc0.size() == 2) begin
         chk("bubble_r0", beat_acc0[0], 42);
         chk("bubble_r1", beat_acc0[1], 46);
      end

      // Reset with two samples in flight.
      clear_logs();
      send(9, 9, 1, 0); send(8, 8, 0, 0);
      aclr = 1'b1;
      #1;
      chk("aclr_async_acc", acc_out0, 0);
      repeat (2) @(posedge clk);
      #1 aclr = 1'b0;
      idle(5);
      chk("aclr_no_beats", beat_acc0.size(), 0);
      send(10, 10, 0, 0);
      idle(5);
      chk("aclr_after_beats", beat_acc0.size(), 1);
      if (beat_acc0.size() == 1) chk("aclr_after_val", beat_acc0[0], 100);

      // Randomised traffic.
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         dataa     = ($urandom_range(0, 3) == 0) ? 8'hff : DW'($urandom_range(0, 255));
         datab     = ($urandom_range(0, 3) == 0) ? 8'hff : DW'($urandom_range(0, 255));
         sload     = ($urandom_range(0, 7) == 0);
         mode      = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         aclr      = (c == 200);
         @(posedge clk);
         #1;
      end
      aclr = 1'b0; out_ready = 1'b1;
      idle(8);
      chk("drain_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
